rand_range_sched: RTL and testbench

//  Shares one constrained-random value source between NREQ requesters in the BSV test

---
 rtl/rand_sched_pkg.sv | 32 +++
 rtl/rand_lfsr32.sv | 28 ++
 rtl/rand_range_sched.sv | 133 +++++++++++++
 tb/tb_rand_range_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_sched_pkg.sv
// Shared types, constants and the round-robin pick helper for the random-range scheduler.
package rand_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        RESP
    } state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;
    localparam int unsigned MAX_REQ   = 16;

    // First set request at or after ptr, wrapping within the nreq active lanes.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [3:0]         ptr,
                                           input int unsigned        nreq);
        logic [3:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = ({28'd0, ptr} + k) % nreq;
            if (!found && (k < nreq) && req[idx[3:0]]) begin
                pick  = idx[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rand_lfsr32.sv
// 32-bit Galois LFSR that advances one step per enabled cycle and reloads its seed on reset.
module rand_lfsr32
    import rand_sched_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_step,
    output logic [31:0] o_value
);

    // An all-zero state would lock up the register, so a zero seed falls back to 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] r_lfsr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= SEED_EFF;
        end else if (i_step) begin
            r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
        end
    end

    assign o_value = r_lfsr;

endmodule

// File: rtl/rand_range_sched.sv
// Round-robin arbiter sharing one LFSR between NREQ requesters, each drawing a value
// constrained to its own [min,max] range and returned over a valid/ready handshake.
module rand_range_sched
    import rand_sched_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16,
    parameter logic [31:0] SEED  = 32'h1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          REQ,
    input  logic [NREQ*WIDTH-1:0]    RMIN,
    input  logic [NREQ*WIDTH-1:0]    RMAX,
    output logic [NREQ-1:0]          GNT,
    output logic                     RESP_VALID,
    input  logic                     RESP_RDY,
    output logic [$clog2(NREQ)-1:0]  RESP_ID,
    output logic [WIDTH-1:0]         RESP_DATA,
    output logic                     RESP_ERR
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned MW  = (WIDTH + 1 > 32) ? WIDTH + 1 : 32;

    state_t           r_state;
    logic [NREQ-1:0]  r_gnt;
    logic             r_valid;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_ptr;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_data;
    logic             r_err;

    logic [31:0]      w_lfsr;
    logic             w_step;
    logic [IDW-1:0]   w_pick;
    logic [WIDTH-1:0] w_min_sel;
    logic [WIDTH-1:0] w_max_sel;
    logic             w_inv;
    logic [WIDTH:0]   w_span;
    logic             w_full;
    logic [WIDTH-1:0] w_mod;
    logic [WIDTH-1:0] w_data;

    assign w_step = (r_state == DRAW) && !RST;

    rand_lfsr32 #(
        .SEED (SEED)
    ) u_lfsr (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_step  (w_step),
        .o_value (w_lfsr)
    );

    assign w_pick = IDW'(rr_pick(MAX_REQ'(REQ), 4'(r_ptr), NREQ));

    always_comb begin
        w_min_sel = '0;
        w_max_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_pick == IDW'(i)) begin
                w_min_sel = RMIN[i*WIDTH +: WIDTH];
                w_max_sel = RMAX[i*WIDTH +: WIDTH];
            end
        end
    end

    // Span is one bit wider than the range so a full 2**WIDTH range stays representable.
    assign w_inv  = r_max < r_min;
    assign w_span = {1'b0, r_max} - {1'b0, r_min} + {{WIDTH{1'b0}}, 1'b1};
    assign w_full = (w_span == {1'b1, {WIDTH{1'b0}}});
    assign w_mod  = WIDTH'(MW'(w_lfsr) % MW'(w_span));

    always_comb begin
        w_data = r_min + w_mod;
        if (w_inv) begin
            w_data = r_min;
        end else if (w_full) begin
            w_data = w_lfsr[WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_ptr   <= '0;
            r_min   <= '0;
            r_max   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                IDLE: begin
                    if (|REQ) begin
                        r_id    <= w_pick;
                        r_min   <= w_min_sel;
                        r_max   <= w_max_sel;
                        r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
                        r_state <= DRAW;
                    end
                end
                DRAW: begin
                    r_data  <= w_data;
                    r_err   <= w_inv;
                    r_valid <= 1'b1;
                    r_state <= RESP;
                end
                RESP: begin
                    if (RESP_RDY) begin
                        r_valid <= 1'b0;
                        r_ptr   <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign GNT        = r_gnt;
    assign RESP_VALID = r_valid;
    assign RESP_ID    = r_id;
    assign RESP_DATA  = r_data;
    assign RESP_ERR   = r_err;

endmodule

// File: tb/tb_rand_range_sched.sv
// Randomized bench for rand_range_sched against a transaction-level model of arbitration and draws.
module tb_rand_range_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  REQ;
    logic [63:0] RMIN;
    logic [63:0] RMAX;
    logic        RESP_RDY;

    logic [3:0]  GNT,  gnt_s0;
    logic        RESP_VALID, valid_s0;
    logic [1:0]  RESP_ID, id_s0;
    logic [15:0] RESP_DATA, data_s0;
    logic        RESP_ERR, err_s0;

    rand_range_sched #(.NREQ(4), .WIDTH(16), .SEED(32'h1)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .RMIN(RMIN), .RMAX(RMAX), .GNT(GNT),
        .RESP_VALID(RESP_VALID), .RESP_RDY(RESP_RDY), .RESP_ID(RESP_ID),
        .RESP_DATA(RESP_DATA), .RESP_ERR(RESP_ERR)
    );

    rand_range_sched #(.NREQ(4), .WIDTH(16), .SEED(32'h0)) dut_s0 (
        .CLK(CLK), .RST(RST), .REQ(REQ), .RMIN(RMIN), .RMAX(RMAX), .GNT(gnt_s0),
        .RESP_VALID(valid_s0), .RESP_RDY(RESP_RDY), .RESP_ID(id_s0),
        .RESP_DATA(data_s0), .RESP_ERR(err_s0)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_lfsr;
    int          m_ptr;
    bit          prev_ok;
    int          prev_delay;
    int          last_gnt;
    logic [15:0] tmin [4];
    logic [15:0] tmax [4];

    // Last observed transaction, for test-specific checks
    logic [3:0]  obs_gnt;
    logic [1:0]  obs_id;
    logic [15:0] obs_data;
    logic        obs_err;
    logic [31:0] used_lfsr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic int rr_model(input logic [3:0] req);
        int i;
        for (int k = 0; k < 4; k++) begin
            i = (m_ptr + k) % 4;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_draw(input longint unsigned mn, input longint unsigned mx,
                                       input longint unsigned lf,
                                       output logic [15:0] d, output logic e);
        longint unsigned span;
        longint unsigned r;
        if (mx < mn) begin
            r = mn;
            e = 1'b1;
        end else begin
            span = mx - mn + 1;
            e    = 1'b0;
            if (span == 65536) r = lf % 65536;
            else               r = mn + (lf % span);
        end
        d = r[15:0];
    endfunction

    task automatic draw(input logic [3:0] req, input int delay, input bit drop);
        int          id;
        int          n;
        logic [3:0]  eg;
        logic [15:0] ed;
        logic        ee;
        id = rr_model(req);
        for (int i = 0; i < 4; i++) begin
            RMIN[i*16 +: 16] = tmin[i];
            RMAX[i*16 +: 16] = tmax[i];
        end
        REQ      = req;
        RESP_RDY = 1'($urandom_range(0, 1));
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (GNT == 4'b0 && n < 8);
        chk("gnt_latency", n, 1);
        eg = 4'b0001 << id;
        chk("gnt_onehot", GNT, eg);
        obs_gnt = GNT;
        if (GNT == 4'b0) begin
            prev_ok = 1'b0;
            REQ = '0;
            return;
        end
        if (prev_ok) chk("gnt_gap", cyc - last_gnt, 3 + prev_delay);
        last_gnt  = cyc;
        used_lfsr = m_lfsr;
        model_draw(tmin[id], tmax[id], m_lfsr, ed, ee);
        // Inputs changed after grant must not affect the draw in flight
        RMIN = {$urandom, $urandom};
        RMAX = {$urandom, $urandom};
        if (drop) REQ = '0;
        @(negedge CLK);
        chk("resp_valid", RESP_VALID, 1);
        chk("gnt_after", GNT, 0);
        chk("resp_id", RESP_ID, id);
        chk("resp_data", RESP_DATA, ed);
        chk("resp_err", RESP_ERR, ee);
        chk("seed0_data", data_s0, ed);
        obs_id   = RESP_ID;
        obs_data = RESP_DATA;
        obs_err  = RESP_ERR;
        m_lfsr   = lfsr_next(m_lfsr);
        for (int d = 0; d < delay; d++) begin
            RESP_RDY = 1'b0;
            @(negedge CLK);
            chk("bp_valid", RESP_VALID, 1);
            chk("bp_data", RESP_DATA, ed);
            chk("bp_id", RESP_ID, id);
            chk("bp_gnt", GNT, 0);
        end
        RESP_RDY = 1'b1;
        @(negedge CLK);
        chk("valid_drop", RESP_VALID, 0);
        RESP_RDY   = 1'b0;
        REQ        = '0;
        m_ptr      = (id + 1) % 4;
        prev_ok    = 1'b1;
        prev_delay = delay;
    endtask

    task automatic model_reset();
        m_lfsr  = 32'h1;
        m_ptr   = 0;
        prev_ok = 1'b0;
    endtask

    initial begin
        logic [3:0]  fair_exp [5];
        bit          seen [11];
        int          nseen;
        int          n;
        int          kind;
        logic [3:0]  rq;

        // Reset with all requesters active
        RST = 1'b1; REQ = 4'b1111; RMIN = '0; RMAX = '0; RESP_RDY = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            chk("rst_gnt", GNT, 0);
            chk("rst_valid", RESP_VALID, 0);
            chk("rst_id", RESP_ID, 0);
            chk("rst_data", RESP_DATA, 0);
            chk("rst_err", RESP_ERR, 0);
        end
        RST = 1'b0;
        model_reset();

        // Fairness from the reset pointer
        fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0010; fair_exp[2] = 4'b0100;
        fair_exp[3] = 4'b1000; fair_exp[4] = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tmin[i] = 16'(i * 100);
            tmax[i] = 16'(i * 100 + 50);
        end
        for (int k = 0; k < 5; k++) begin
            draw(4'b1111, 0, 1'b0);
            chk("fair_gnt", obs_gnt, fair_exp[k]);
        end

        // Backpressure then release
        draw(4'b0001, 5, 1'b0);
        draw(4'b0010, 0, 1'b0);

        // Single requester, all values of [10,20] must show up
        tmin[2] = 16'd10;
        tmax[2] = 16'd20;
        for (int v = 0; v < 11; v++) seen[v] = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            draw(4'b0100, 0, 1'($urandom_range(0, 1)));
            chk("single_id", obs_id, 2);
            chk("single_range", (obs_data >= 16'd10 && obs_data <= 16'd20), 1);
            if (obs_data >= 16'd10 && obs_data <= 16'd20) seen[obs_data - 16'd10] = 1'b1;
        end
        nseen = 0;
        for (int v = 0; v < 11; v++) nseen += int'(seen[v]);
        chk("single_coverage", nseen, 11);

        // Range boundaries
        tmin[1] = 16'd7;  tmax[1] = 16'd7;
        draw(4'b0010, 0, 1'b0);
        chk("eq_data", obs_data, 16'd7);
        chk("eq_err", obs_err, 0);
        tmin[1] = 16'd0;  tmax[1] = 16'hFFFF;
        draw(4'b0010, 1, 1'b0);
        chk("full_data", obs_data, used_lfsr[15:0]);
        tmin[1] = 16'd9;  tmax[1] = 16'd3;
        draw(4'b0010, 0, 1'b0);
        chk("inv_data", obs_data, 16'd9);
        chk("inv_err", obs_err, 1);

        // Reset while a response is pending
        tmin[1] = 16'd100; tmax[1] = 16'd200;
        RMIN[31:16] = tmin[1]; RMAX[31:16] = tmax[1];
        REQ = 4'b0010; RESP_RDY = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!RESP_VALID && n < 8);
        chk("mid_valid_seen", RESP_VALID, 1);
        RST = 1'b1; REQ = '0;
        @(negedge CLK);
        chk("mid_rst_valid", RESP_VALID, 0);
        chk("mid_rst_gnt", GNT, 0);
        chk("mid_rst_valid_s0", valid_s0, 0);
        RST = 1'b0;
        model_reset();
        draw(4'b0010, 0, 1'b0);
        chk("reload_data", obs_data, 16'd100 + 16'(32'h1 % 101));

        // Randomized mix of requests, ranges and backpressure
        for (int k = 0; k < 150; k++) begin
            for (int i = 0; i < 4; i++) begin
                kind = $urandom_range(0, 3);
                case (kind)
                    0: begin tmin[i] = 16'($urandom); tmax[i] = 16'($urandom); end
                    1: begin tmin[i] = 16'($urandom); tmax[i] = tmin[i]; end
                    2: begin tmin[i] = 16'd0; tmax[i] = 16'hFFFF; end
                    default: begin
                        tmin[i] = 16'($urandom_range(0, 60000));
                        tmax[i] = tmin[i] + 16'($urandom_range(0, 300));
                    end
                endcase
            end
            rq = 4'($urandom_range(1, 15));
            draw(rq, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
